// File: rtl/lui_hazard_unit_pkg.sv
// Shared types and constants for the LUI hazard tracker and its matchers.
package lui_hazard_unit_pkg;

    localparam int unsigned TRACK_DEPTH = 3;
    localparam logic [4:0]  REG_X0      = 5'd0;
    localparam int unsigned UIMM_SHIFT  = 12;

    typedef struct packed {
        logic        v;
        logic        lui;
        logic [4:0]  rd;
        logic [31:0] val;
    } track_entry_t;

    function automatic logic [31:0] u_value(input logic [19:0] imm);
        return {12'b0, imm} << UIMM_SHIFT;
    endfunction

endpackage

// File: rtl/lui_hazard_unit_track_match.sv
// Youngest-first priority matcher: the first valid entry writing i_rs decides,
// so non-LUI writers shadow older LUIs to the same register.
module lui_track_match
    import lui_hazard_unit_pkg::*;
#(
    parameter int unsigned DEPTH = TRACK_DEPTH
) (
    input  track_entry_t i_entries [DEPTH],
    input  logic [4:0]   i_rs,
    output logic         o_hit,
    output logic [31:0]  o_val
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_hit   = 1'b0;
        o_val   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_found && i_entries[i].v && (i_entries[i].rd == i_rs) && (i_rs != REG_X0)) begin
                w_found = 1'b1;
                o_hit   = i_entries[i].lui;
                o_val   = i_entries[i].val;
            end
        end
    end

endmodule

// File: rtl/lui_hazard_unit.sv
// Tracks in-flight register writers (EX..WB) and flags decode operands that
// must take a forwarded LUI value; also counts hazard cycles.
module lui_hazard_unit
    import lui_hazard_unit_pkg::*;
#(
    parameter int unsigned DEPTH = TRACK_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wr_rd,
    input  logic             id_is_lui,
    input  logic [19:0]      id_imm_u,
    input  logic             stall,
    input  logic             flush,
    output logic             luiHaz_rs1,
    output logic             luiHaz_rs2,
    output logic [31:0]      lui_fwd_rs1,
    output logic [31:0]      lui_fwd_rs2,
    output logic [CNT_W-1:0] haz_count
);

    track_entry_t     r_entries [DEPTH];
    track_entry_t     w_new;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit1;
    logic             w_hit2;
    logic [31:0]      w_val1;
    logic [31:0]      w_val2;
    logic             w_any;

    // A flushed decode slot enters EX as a bubble, but older entries still shift.
    always_comb begin
        w_new     = '0;
        w_new.v   = id_valid & id_wr_rd & ~flush;
        w_new.lui = id_is_lui;
        w_new.rd  = id_rd;
        w_new.val = u_value(id_imm_u);
    end

    lui_track_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .i_entries (r_entries),
        .i_rs      (id_rs1),
        .o_hit     (w_hit1),
        .o_val     (w_val1)
    );

    lui_track_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .i_entries (r_entries),
        .i_rs      (id_rs2),
        .o_hit     (w_hit2),
        .o_val     (w_val2)
    );

    always_comb begin
        luiHaz_rs1  = id_valid & id_use_rs1 & w_hit1;
        luiHaz_rs2  = id_valid & id_use_rs2 & w_hit2;
        lui_fwd_rs1 = luiHaz_rs1 ? w_val1 : '0;
        lui_fwd_rs2 = luiHaz_rs2 ? w_val2 : '0;
        w_any       = luiHaz_rs1 | luiHaz_rs2;
    end

    // Stall freezes both tracker and counter and overrides flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_cnt <= '0;
        end else if (!stall) begin
            r_entries[0] <= w_new;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_entries[i] <= r_entries[i-1];
            end
            if (w_any && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign haz_count = r_cnt;

endmodule
